// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state miss FSM.
// Hits are served combinationally in IDLE; misses fetch one word and include saturating hit/miss counters.
module icache #(
  parameter int WORD_W = 32,
  parameter int ITAG_W = 26,
  parameter int IIDX_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              iflush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hitcnt,
  output logic [31:0]       misscnt
);

  localparam int NENT = 1 << IIDX_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]        state_r;
  logic [NENT-1:0]   valid_r;
  logic [ITAG_W-1:0] tag_r  [NENT];
  logic [WORD_W-1:0] data_r [NENT];
  logic [WORD_W-1:0] miss_addr_r;
  logic [31:0]       hitcnt_r;
  logic [31:0]       misscnt_r;

  logic [IIDX_W-1:0] idx_s;
  logic [ITAG_W-1:0] tag_s;
  logic [IIDX_W-1:0] fill_idx_s;
  logic [ITAG_W-1:0] fill_tag_s;
  logic              hit_s;
  logic              miss_s;
  logic              fill_s;
  logic              unused_s;

  // Address decode, hit/miss detection and the fill qualifier
  always_comb begin
    idx_s      = imemaddr[2 +: IIDX_W];
    tag_s      = imemaddr[IIDX_W+2 +: ITAG_W];
    fill_idx_s = miss_addr_r[2 +: IIDX_W];
    fill_tag_s = miss_addr_r[IIDX_W+2 +: ITAG_W];
    unused_s   = ^imemaddr[1:0];
    hit_s      = (state_r == IDLE) && imemREN && valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    miss_s     = (state_r == IDLE) && imemREN && !hit_s;
    // Flush wins over a coincident fill, so the write is suppressed outright.
    fill_s     = (state_r == FETCH) && !iwait && !iflush;
  end

  // Processor- and memory-side outputs
  always_comb begin
    ihit     = hit_s;
    imemload = {WORD_W{1'b0}};
    if (hit_s) begin
      imemload = data_r[idx_s];
    end else begin
      imemload = {WORD_W{1'b0}};
    end
    iREN  = (state_r == FETCH);
    iaddr = {WORD_W{1'b0}};
    if (state_r == FETCH) begin
      iaddr = miss_addr_r;
    end else begin
      iaddr = {WORD_W{1'b0}};
    end
    hitcnt  = hitcnt_r;
    misscnt = misscnt_r;
  end

  // Miss FSM, miss-address latch and valid bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      valid_r     <= {NENT{1'b0}};
      miss_addr_r <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            miss_addr_r <= {imemaddr[WORD_W-1:2], 2'b00};
            state_r     <= FETCH;
          end
        end
        FETCH: begin
          if (iflush || !iwait) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (iflush) begin
        valid_r <= {NENT{1'b0}};
      end else if (fill_s) begin
        valid_r[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data storage; contents are don't-care while the valid bit is clear
  always_ff @(posedge CLK) begin
    if (!RST && fill_s) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= iload;
    end
  end

  // Saturating performance counters, untouched by flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      hitcnt_r  <= 32'd0;
      misscnt_r <= 32'd0;
    end else begin
      if (hit_s && (hitcnt_r != 32'hFFFF_FFFF)) begin
        hitcnt_r <= hitcnt_r + 32'd1;
      end
      if (miss_s && (misscnt_r != 32'hFFFF_FFFF)) begin
        misscnt_r <= misscnt_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic
// compared against a line-address cache model kept in the bench.
module tb_icache;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        iflush = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'd0;
  logic [31:0] hitcnt;
  logic [31:0] misscnt;

  int n_tests = 0;
  int n_fail  = 0;

  icache dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .hitcnt(hitcnt), .misscnt(misscnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: each line remembers the full word address it holds.
  bit          m_valid [16];
  logic [29:0] m_line  [16];
  logic [31:0] m_data  [16];
  bit          m_fetch;
  logic [31:0] m_maddr;
  logic [31:0] m_hc;
  logic [31:0] m_mc;

  function automatic bit exp_hit_f();
    int i;
    i = int'(imemaddr[5:2]);
    return !m_fetch && imemREN && m_valid[i] && (m_line[i] == imemaddr[31:2]);
  endfunction

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic tick();
    bit h;
    int fi;
    h = exp_hit_f();
    @(posedge CLK);
    if (RST) begin
      m_fetch = 1'b0; m_maddr = 32'd0; m_hc = 32'd0; m_mc = 32'd0;
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else begin
      if (h && m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 32'd1;
      if (m_fetch) begin
        if (!iflush && !iwait) begin
          fi = int'(m_maddr[5:2]);
          m_valid[fi] = 1'b1; m_line[fi] = m_maddr[31:2]; m_data[fi] = iload;
        end
        if (iflush || !iwait) m_fetch = 1'b0;
      end else if (imemREN && !h) begin
        m_fetch = 1'b1;
        m_maddr = {imemaddr[31:2], 2'b00};
        if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
      end
      if (iflush) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b0; imemaddr = 32'd0; iload = 32'd0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b0; iload = d;
    tick(); tick();
    imemREN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit got=%b exp=0", ihit); end
    n_tests++; if (imemload !== 32'd0) begin n_fail++; $display("FAIL reset_imemload got=%h exp=0", imemload); end
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN got=%b exp=0", iREN); end
    n_tests++; if (iaddr !== 32'd0) begin n_fail++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
    n_tests++; if (hitcnt !== 32'd0 || misscnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters got=%h/%h exp=0/0", hitcnt, misscnt); end
  endtask

  task automatic test_cold_miss();
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h0000_0040; iwait = 1'b1;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_first_ihit got=%b exp=0", ihit); end
    tick();
    for (int k = 0; k < 4; k++) begin
      iwait = (k < 3); iload = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge CLK);
      n_tests++; if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin n_fail++; $display("FAIL cold_fetch%0d got iREN=%b iaddr=%h ihit=%b exp 1/00000040/0", k, iREN, iaddr, ihit); end
      tick();
    end
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b1 || imemload !== 32'hDEAD_BEEF || iREN !== 1'b0) begin n_fail++; $display("FAIL cold_hit got ihit=%b load=%h iREN=%b exp 1/deadbeef/0", ihit, imemload, iREN); end
    tick();
    imemREN = 1'b0;
    @(negedge CLK);
    n_tests++; if (misscnt !== 32'd1 || hitcnt !== 32'd1) begin n_fail++; $display("FAIL cold_counters got miss=%0d hit=%0d exp 1/1", misscnt, hitcnt); end
  endtask

  task automatic test_conflict();
    do_reset();
    fill(32'h0000_0040, 32'h1111_1111);
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_80_ihit got=%b exp=0", ihit); end
    fill(32'h0000_0080, 32'h2222_2222);
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_40_ihit got=%b exp=0", ihit); end
    fill(32'h0000_0040, 32'h3333_3333);
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b1 || imemload !== 32'h3333_3333) begin n_fail++; $display("FAIL conflict_refill got ihit=%b load=%h exp 1/33333333", ihit, imemload); end
    n_tests++; if (misscnt !== 32'd3) begin n_fail++; $display("FAIL conflict_misscnt got=%0d exp=3", misscnt); end
    imemREN = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(32'h0000_0004, 32'hAAAA_0004);
    fill(32'h0000_0008, 32'hBBBB_0008);
    imemREN = 1'b1; imemaddr = 32'h0000_0004;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b1 || imemload !== 32'hAAAA_0004) begin n_fail++; $display("FAIL b2b_first got ihit=%b load=%h exp 1/aaaa0004", ihit, imemload); end
    tick();
    imemaddr = 32'h0000_0008;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b1 || imemload !== 32'hBBBB_0008) begin n_fail++; $display("FAIL b2b_second got ihit=%b load=%h exp 1/bbbb0008", ihit, imemload); end
    tick();
    imemREN = 1'b0;
    @(negedge CLK);
    n_tests++; if (hitcnt !== 32'd2) begin n_fail++; $display("FAIL b2b_hitcnt got=%0d exp=2", hitcnt); end
  endtask

  task automatic test_flush();
    do_reset();
    fill(32'h0000_0004, 32'hCAFE_0004);
    iflush = 1'b1; tick(); iflush = 1'b0;
    imemREN = 1'b1; imemaddr = 32'h0000_0004;
    @(negedge CLK);
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_ihit got=%b exp=0", ihit); end
    tick();
    @(negedge CLK);
    n_tests++; if (iREN !== 1'b1 || iaddr !== 32'h4) begin n_fail++; $display("FAIL flush_refetch got iREN=%b iaddr=%h exp 1/00000004", iREN, iaddr); end
    iflush = 1'b1; iwait = 1'b0; iload = 32'h5555_5555;
    tick();
    iflush = 1'b0; imemREN = 1'b0;
    @(negedge CLK);
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL flush_abort_iREN got=%b exp=0", iREN); end
    imemREN = 1'b1;
    #1;
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_abort_nowrite got=%b exp=0", ihit); end
    imemREN = 1'b0;
  endtask

  task automatic test_mid_fetch_reset();
    do_reset();
    fill(32'h0000_0020, 32'h7777_0020);
    imemREN = 1'b1; imemaddr = 32'h0000_0010; iwait = 1'b1;
    tick();
    iwait = 1'b0; iload = 32'h9999_0010; RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    n_tests++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL rstfetch_iREN got=%b exp=0", iREN); end
    n_tests++; if (hitcnt !== 32'd0 || misscnt !== 32'd0) begin n_fail++; $display("FAIL rstfetch_counters got=%h/%h exp=0/0", hitcnt, misscnt); end
    n_tests++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rstfetch_read_misses got=%b exp=0", ihit); end
    imemREN = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    fill(32'h0000_0004, 32'h1234_5678);
    @(negedge CLK);
    force dut.hitcnt_r = 32'hFFFF_FFFE;
    #2;
    release dut.hitcnt_r;
    m_hc = 32'hFFFF_FFFE;
    imemREN = 1'b1; imemaddr = 32'h0000_0004;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_tests++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL sat_hit%0d got=%b exp=1", k, ihit); end
      tick();
    end
    imemREN = 1'b0;
    @(negedge CLK);
    n_tests++; if (hitcnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hitcnt got=%h exp=ffffffff", hitcnt); end
  endtask

  task automatic test_random();
    int fails_before;
    logic [31:0] e_load;
    bit e_hit;
    do_reset();
    fails_before = n_fail;
    for (int c = 0; c < 600; c++) begin
      RST      = ($urandom_range(0, 199) == 0);
      imemREN  = ($urandom_range(0, 3) != 0);
      imemaddr = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      iwait    = $urandom_range(0, 1);
      iflush   = ($urandom_range(0, 39) == 0);
      iload    = $urandom;
      @(negedge CLK);
      e_hit  = exp_hit_f();
      e_load = e_hit ? m_data[imemaddr[5:2]] : 32'd0;
      n_tests++; if (ihit !== e_hit || imemload !== e_load) begin n_fail++; $display("FAIL rnd_hit c=%0d got %b/%h exp %b/%h", c, ihit, imemload, e_hit, e_load); end
      n_tests++; if (iREN !== m_fetch || iaddr !== (m_fetch ? m_maddr : 32'd0)) begin n_fail++; $display("FAIL rnd_mem c=%0d got %b/%h exp %b/%h", c, iREN, iaddr, m_fetch, m_fetch ? m_maddr : 32'd0); end
      n_tests++; if (hitcnt !== m_hc || misscnt !== m_mc) begin n_fail++; $display("FAIL rnd_cnt c=%0d got %0d/%0d exp %0d/%0d", c, hitcnt, misscnt, m_hc, m_mc); end
      if (n_fail - fails_before > 10) break;
      tick();
    end
    RST = 1'b0; imemREN = 1'b0; iflush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_line[i] = 30'd0; m_data[i] = 32'd0; end
    m_fetch = 1'b0; m_maddr = 32'd0; m_hc = 32'd0; m_mc = 32'd0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_mid_fetch_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL take parameter WORD_W, default 32, data/address width (cpu_types_pkg value).
REQ-002 SHALL take parameter ITAG_W, default 26, tag width, address bits [31:6].
REQ-003 SHALL take parameter IIDX_W, default 4, index width, address bits [5:2]; 16 entries.
REQ-004 SHALL have port CLK  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port imemREN  in  1  processor instruction read request.
REQ-007 SHALL have port imemaddr  in  32  processor fetch address; bits [1:0] ignored.
REQ-008 SHALL have port iflush  in  1  invalidate all entries.
REQ-009 SHALL have port ihit  out  1  request served this cycle.
REQ-010 SHALL have port imemload  out  32  instruction word returned to the processor.
REQ-011 SHALL have port iREN  out  1  memory read request.
REQ-012 SHALL have port iaddr  out  32  memory word address, bits [1:0] = 00.
REQ-013 SHALL have port iwait  in  1  memory busy; fill data is valid when iwait=0 while iREN=1.
REQ-014 SHALL have port iload  in  32  memory read data.
REQ-015 SHALL have ports hitcnt and misscnt  out  32 each  performance counters.

Function
REQ-016 SHALL be direct-mapped, 16 entries, one word per block, each entry holding a valid bit, a 26-bit tag and a 32-bit word.
REQ-017 SHALL decode the address as tag=imemaddr[31:6], idx=imemaddr[5:2].
REQ-018 SHALL have an FSM with states IDLE and FETCH.
REQ-019 SHALL drive ihit=1 combinationally, in the same cycle, when state=IDLE, imemREN=1, valid[idx]=1 and tag[idx]==tag.
REQ-020 SHALL drive imemload=data[idx] when ihit=1, else 0.
REQ-021 SHALL, in IDLE with imemREN=1 and a miss, latch {imemaddr[31:2],2'b00} into a miss-address register and move to FETCH on the next edge.
REQ-022 SHALL drive iREN=1 and iaddr=latched address only in FETCH; otherwise iREN=0 and iaddr=0.
REQ-023 SHALL, in FETCH with iwait=0, write iload, tag and valid=1 into the entry selected by the latched address, and return to IDLE.
REQ-024 SHALL hold FETCH while iwait=1 and ignore imemaddr/imemREN changes; the fill completes even if imemREN drops.
REQ-025 SHALL have a minimum miss-to-hit latency of 2 cycles, with iwait=0 in the first FETCH cycle: miss at cycle 0, FETCH at cycle 1, ihit at cycle 2.
REQ-026 SHALL never assert ihit in FETCH.
REQ-027 SHALL, when iflush=1, clear all valid bits on the next edge; in FETCH, flush aborts the fill (no write) and returns to IDLE.
REQ-028 SHALL give flush priority over a coincident fill; tags and data need not be cleared.
REQ-029 SHALL increment hitcnt once per cycle with ihit=1.
REQ-030 SHALL increment misscnt once per IDLE->FETCH transition.
REQ-031 SHALL saturate both counters at 0xFFFFFFFF; iflush does not clear them.
REQ-032 SHALL allow back-to-back hits on different addresses in consecutive cycles.

Reset
REQ-033 SHALL, while RST=1 at an edge, set state=IDLE, all valid bits=0, miss-address=0, hitcnt=0 and misscnt=0, with priority over all other events.
REQ-034 SHALL, on reset mid-FETCH, abandon the fill with no entry written, giving iREN=0 in the following cycle.
REQ-035 SHALL hold ihit=0, imemload=0, iREN=0 and iaddr=0 in the cycle after reset.

Verification
REQ-036 SHALL verify cold miss: reset, then imemREN=1, addr 0x00000040, with iwait=1 for 3 cycles then iload=0xDEADBEEF -> iREN=1 and iaddr=0x40 for 4 cycles, then ihit=1 with imemload=0xDEADBEEF, misscnt=1, hitcnt=1.
REQ-037 SHALL verify conflict: fill 0x00000040, then read 0x00000080 (same idx 0, different tag) -> miss and refill; re-reading 0x40 misses again, misscnt=3.
REQ-038 SHALL verify back-to-back hits: fill 0x04 and 0x08, then read them in consecutive cycles -> ihit=1 both cycles, hitcnt increments by 2.
REQ-039 SHALL verify flush: after filling 0x04, pulse iflush, then read 0x04 -> miss (iREN=1); iflush during FETCH -> no write and IDLE next cycle.
REQ-040 SHALL verify mid-fetch reset: RST=1 while in FETCH with iwait=1 -> next cycle iREN=0, counters 0, and a read of the same address misses.
REQ-041 SHALL verify saturation: force hitcnt to 0xFFFFFFFE, then 3 hits -> hitcnt=0xFFFFFFFF.
